// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for the multicycle RV32M divider.
// Handles divide-by-zero and signed overflow locally, with a watchdog on the divider.
module div_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_is_div,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            flush_ex,
  output logic            stall,
  output logic            div_valid,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic [2:0]      div_funct3,
  output logic            div_flush,
  input  logic [XLEN-1:0] div_res,
  input  logic            div_done,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              tmo_r, tmo_nxt_s;
  logic              div_valid_r, div_valid_nxt_s;
  logic [XLEN-1:0]   div_a_r, div_a_nxt_s;
  logic [XLEN-1:0]   div_b_r, div_b_nxt_s;
  logic [2:0]        div_funct3_r, div_funct3_nxt_s;
  logic [4:0]        wb_rd_r, wb_rd_nxt_s;
  logic [XLEN-1:0]   wb_data_r, wb_data_nxt_s;
  logic              req_s, accept_s, special_s, busy_live_s, cnt_max_s, wb_valid_s;

  // Divide-by-zero or signed overflow: the answer is known without the divider.
  function automatic logic is_special(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic ovf;
    ovf = ~f3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == {XLEN{1'b1}});
    return (b == {XLEN{1'b0}}) | ovf;
  endfunction

  // Zero divisor is checked first so it takes priority over overflow.
  function automatic logic [XLEN-1:0] special_result(input logic [2:0] f3,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    if (b == {XLEN{1'b0}}) begin
      res = f3[1] ? a : {XLEN{1'b1}};
    end else begin
      res = f3[1] ? {XLEN{1'b0}} : a;
    end
    return res;
  endfunction

  assign req_s       = ex_valid & ex_is_div & ~flush_ex;
  assign accept_s    = (state_r == IDLE) & req_s;
  assign special_s   = is_special(ex_funct3, ex_rs1, ex_rs2);
  assign busy_live_s = (state_r == BUSY) & ~flush_ex;
  assign cnt_max_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
  assign wb_valid_s  = (state_r == RESP) & ~flush_ex;

  assign stall       = ~reset & req_s & (state_r != RESP);
  assign div_flush   = flush_ex & (state_r == BUSY);
  assign div_valid   = div_valid_r;
  assign div_a       = div_a_r;
  assign div_b       = div_b_r;
  assign div_funct3  = div_funct3_r;
  assign wb_valid    = wb_valid_s;
  assign wb_rd       = wb_rd_r;
  assign wb_data     = wb_data_r;
  assign timeout_err = wb_valid_s & tmo_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a flush from any state abandons the op.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_ex) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_nxt_s = special_s ? RESP : BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BUSY: begin
          if (div_done || cnt_max_s) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        RESP:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, watchdog counter and timeout flag.
  always_comb begin
    div_valid_nxt_s  = accept_s & ~special_s;
    div_a_nxt_s      = div_a_r;
    div_b_nxt_s      = div_b_r;
    div_funct3_nxt_s = div_funct3_r;
    wb_rd_nxt_s      = wb_rd_r;
    wb_data_nxt_s    = wb_data_r;
    cnt_nxt_s        = cnt_r;
    tmo_nxt_s        = tmo_r;
    if (accept_s) begin
      div_a_nxt_s      = ex_rs1;
      div_b_nxt_s      = ex_rs2;
      div_funct3_nxt_s = ex_funct3;
      wb_rd_nxt_s      = ex_rd;
      cnt_nxt_s        = {CNT_W{1'b0}};
      tmo_nxt_s        = 1'b0;
      if (special_s) begin
        wb_data_nxt_s = special_result(ex_funct3, ex_rs1, ex_rs2);
      end else begin
        wb_data_nxt_s = wb_data_r;
      end
    end else if (busy_live_s) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
      if (div_done) begin
        wb_data_nxt_s = div_res;
      end else if (cnt_max_s) begin
        wb_data_nxt_s = {XLEN{1'b0}};
        tmo_nxt_s     = 1'b1;
      end else begin
        wb_data_nxt_s = wb_data_r;
      end
    end else begin
      tmo_nxt_s = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_valid_r  <= 1'b0;
      div_a_r      <= {XLEN{1'b0}};
      div_b_r      <= {XLEN{1'b0}};
      div_funct3_r <= 3'b000;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= {XLEN{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      tmo_r        <= 1'b0;
    end else begin
      div_valid_r  <= div_valid_nxt_s;
      div_a_r      <= div_a_nxt_s;
      div_b_r      <= div_b_nxt_s;
      div_funct3_r <= div_funct3_nxt_s;
      wb_rd_r      <= wb_rd_nxt_s;
      wb_data_r    <= wb_data_nxt_s;
      cnt_r        <= cnt_nxt_s;
      tmo_r        <= tmo_nxt_s;
    end
  end

endmodule
